// File: rtl/lsu_mc.sv
// lsu_mc: multicycle load/store unit for an RV32I multicycle core.
//
// Converts byte/half/word loads and stores (signed and unsigned) into
// whole-word accesses on a word-addressed data memory with combinational
// read and a single whole-word write enable. Sub-word stores are done as
// read-modify-write. Misaligned, illegal or out-of-range requests complete
// with err_o=1 and never touch memory.
//
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   req_i              request strobe, sampled only while ready_o=1
//   is_store_i         1 = store, 0 = load
//   funct3_i           RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr_i             byte address
//   wdata_i            store data (low bits used for sub-word stores)
//   ready_o            idle, able to accept a request
//   done_o             one-cycle completion pulse
//   err_o              valid with done_o, 1 = request rejected
//   rdata_o            extended load result, held until the next load completes
//   dmem_addr_o        word index to memory (byte address >> 2)
//   dmem_wdata_o       full word written to memory
//   dmem_we_o          memory write enable
//   dmem_rdata_i       combinational memory read data for dmem_addr_o
module lsu_mc #(
    parameter int DEPTH = 2048
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic        dmem_we_o,
    input  logic [31:0] dmem_rdata_i
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state_reg, state_next;
    logic        is_store_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        err_reg;
    logic [31:0] rbuf_reg;
    logic [31:0] rdata_reg;
    // Last word index / write word driven, so the memory port holds steady
    // outside RD and WR.
    logic [31:0] addr_hold_reg;
    logic [31:0] wdata_hold_reg;

    logic        f3_bad, align_bad, range_bad, req_err;
    logic [31:0] word_index;
    logic [31:0] merged;
    logic [31:0] load_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Request checking on the live inputs, so the verdict is captured at accept.
    always_comb begin
        if (is_store_i)
            f3_bad = funct3_i[2] | (funct3_i[1:0] == 2'b11);
        else
            f3_bad = (funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11);
        align_bad = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                    ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        range_bad = ({2'b00, addr_i[31:2]} >= DEPTH_W);
        req_err   = f3_bad | align_bad | range_bad;
    end

    assign word_index = {2'b00, addr_reg[31:2]};

    // Store word: SW takes wdata whole; SB/SH splice a lane into the read buffer.
    always_comb begin
        merged = rbuf_reg;
        case (funct3_reg[1:0])
            2'b00:   merged[{addr_reg[1:0], 3'b000} +: 8] = wdata_reg[7:0];
            2'b01:   merged[{addr_reg[1], 4'b0000} +: 16] = wdata_reg[15:0];
            default: merged = wdata_reg;
        endcase
    end

    // Load lane selection and extension from the memory word being read.
    always_comb begin
        ld_byte = dmem_rdata_i[{addr_reg[1:0], 3'b000} +: 8];
        ld_half = dmem_rdata_i[{addr_reg[1], 4'b0000} +: 16];
        case (funct3_reg)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {24'h000000, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_ext = {16'h0000, ld_half};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next state and outputs.
    always_comb begin
        state_next   = state_reg;
        ready_o      = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = addr_hold_reg;
        dmem_wdata_o = wdata_hold_reg;
        case (state_reg)
            IDLE: begin
                ready_o = 1'b1;
                if (req_i) begin
                    if (req_err)
                        state_next = DONE;
                    else if (is_store_i && (funct3_i[1:0] == 2'b10))
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD: begin
                dmem_addr_o = word_index;
                state_next  = is_store_reg ? WR : DONE;
            end
            WR: begin
                dmem_we_o    = 1'b1;
                dmem_addr_o  = word_index;
                dmem_wdata_o = merged;
                state_next   = DONE;
            end
            DONE: begin
                done_o     = 1'b1;
                err_o      = err_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            is_store_reg   <= 1'b0;
            funct3_reg     <= 3'b000;
            addr_reg       <= 32'h0;
            wdata_reg      <= 32'h0;
            err_reg        <= 1'b0;
            rbuf_reg       <= 32'h0;
            rdata_reg      <= 32'h0;
            addr_hold_reg  <= 32'h0;
            wdata_hold_reg <= 32'h0;
        end else begin
            if (state_reg == IDLE && req_i) begin
                is_store_reg <= is_store_i;
                funct3_reg   <= funct3_i;
                addr_reg     <= addr_i;
                wdata_reg    <= wdata_i;
                err_reg      <= req_err;
            end
            if (state_reg == RD) begin
                rbuf_reg <= dmem_rdata_i;
                if (!is_store_reg)
                    rdata_reg <= load_ext;
            end
            if (state_reg == RD || state_reg == WR)
                addr_hold_reg <= word_index;
            if (state_reg == WR)
                wdata_hold_reg <= merged;
        end
    end

    assign rdata_o = rdata_reg;

endmodule

// File: tb/tb_lsu_mc.sv
// Testbench for lsu_mc: table of directed load/store/error vectors with
// hand-computed results, plus hand-written busy-handling and mid-operation
// reset sequences. Includes a behavioural word-addressed data memory.
module tb_lsu_mc;

    localparam int DEPTH = 2048;

    logic        clk_i;
    logic        rstn_i;
    logic        req_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_we_o;
    logic [31:0] dmem_rdata_i;

    logic [31:0] mem [0:DEPTH-1];

    int n_cmp;
    int n_bad;

    lsu_mc #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_i        (req_i),
        .is_store_i   (is_store_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .ready_o      (ready_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_rdata_i (dmem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Data memory: combinational read, whole-word write on the rising edge.
    assign dmem_rdata_i = mem[dmem_addr_o[10:0]];
    always @(posedge clk_i) begin
        if (dmem_we_o)
            mem[dmem_addr_o[10:0]] <= dmem_wdata_o;
    end

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          we;
        int          midx;
        logic [31:0] mval;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request and follow it to done_o. Returns latency counted from
    // the accept edge, err_o at done, and the number of dmem_we_o cycles.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic err, output int we);
        int guard;
        lat = 0; err = 1'b0; we = 0;
        @(negedge clk_i);
        guard = 0;
        while (!ready_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        is_store_i = st; funct3_i = f3; addr_i = addr; wdata_i = wd;
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        lat = 1;
        while (!done_o && lat < 10) begin
            if (dmem_we_o) we++;
            @(negedge clk_i);
            lat++;
        end
        if (!done_o) lat = -1;
        err = err_o;
    endtask

    function automatic vec_t mk(logic st, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                                int lat, logic err, logic [31:0] rdata, int we, int midx,
                                logic [31:0] mval);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd; v.lat = lat; v.err = err;
        v.rdata = rdata; v.we = we; v.midx = midx; v.mval = mval;
        return v;
    endfunction

    initial begin
        int lat, we, guard, we_cnt, done_cnt, we_first, we_second, done_seen;
        logic err;
        n_cmp = 0;
        n_bad = 0;

        // Loads (mem[4]=8899AABB, mem[5]=7F008001, mem[2047]=12345678).
        vecs[0]  = mk(0, 3'b000, 32'h13,   32'h0, 2, 0, 32'hFFFFFF88, 0, 4, 32'h8899AABB);
        vecs[1]  = mk(0, 3'b100, 32'h13,   32'h0, 2, 0, 32'h00000088, 0, 4, 32'h8899AABB);
        vecs[2]  = mk(0, 3'b001, 32'h12,   32'h0, 2, 0, 32'hFFFF8899, 0, 4, 32'h8899AABB);
        vecs[3]  = mk(0, 3'b101, 32'h10,   32'h0, 2, 0, 32'h0000AABB, 0, 4, 32'h8899AABB);
        vecs[4]  = mk(0, 3'b010, 32'h10,   32'h0, 2, 0, 32'h8899AABB, 0, 4, 32'h8899AABB);
        vecs[5]  = mk(0, 3'b001, 32'h16,   32'h0, 2, 0, 32'h00007F00, 0, 5, 32'h7F008001);
        vecs[6]  = mk(0, 3'b000, 32'h14,   32'h0, 2, 0, 32'h00000001, 0, 5, 32'h7F008001);
        vecs[7]  = mk(0, 3'b001, 32'h14,   32'h0, 2, 0, 32'hFFFF8001, 0, 5, 32'h7F008001);
        vecs[8]  = mk(0, 3'b010, 32'h1FFC, 32'h0, 2, 0, 32'h12345678, 0, 2047, 32'h12345678);
        // Stores: rdata_o keeps the last load result.
        vecs[9]  = mk(1, 3'b000, 32'h11, 32'h123456CC, 3, 0, 32'h12345678, 1, 4, 32'h8899CCBB);
        vecs[10] = mk(1, 3'b001, 32'h12, 32'h0000BEEF, 3, 0, 32'h12345678, 1, 4, 32'hBEEFCCBB);
        vecs[11] = mk(1, 3'b010, 32'h20, 32'hDEADBEEF, 2, 0, 32'h12345678, 1, 8, 32'hDEADBEEF);
        // Errors: one cycle, no write, rdata_o unchanged.
        vecs[12] = mk(1, 3'b001, 32'h11,   32'h0000FFFF, 1, 1, 32'h12345678, 0, 4, 32'hBEEFCCBB);
        vecs[13] = mk(0, 3'b010, 32'h22,   32'h0, 1, 1, 32'h12345678, 0, 8, 32'hDEADBEEF);
        vecs[14] = mk(0, 3'b011, 32'h10,   32'h0, 1, 1, 32'h12345678, 0, 4, 32'hBEEFCCBB);
        vecs[15] = mk(0, 3'b010, 32'h2000, 32'h0, 1, 1, 32'h12345678, 0, 4, 32'hBEEFCCBB);
        vecs[16] = mk(1, 3'b011, 32'h10,   32'hFFFFFFFF, 1, 1, 32'h12345678, 0, 4, 32'hBEEFCCBB);
        // Read back the modified word.
        vecs[17] = mk(0, 3'b010, 32'h10, 32'h0, 2, 0, 32'hBEEFCCBB, 0, 4, 32'hBEEFCCBB);
        vecs[18] = mk(0, 3'b100, 32'h12, 32'h0, 2, 0, 32'h000000EF, 0, 4, 32'hBEEFCCBB);

        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        mem[4]    = 32'h8899AABB;
        mem[5]    = 32'h7F008001;
        mem[2047] = 32'h12345678;

        req_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'b000; addr_i = 32'h0; wdata_i = 32'h0;
        rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset ready", 32'(ready_o), 32'd1);
        check("reset done", 32'(done_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        check("reset rdata", rdata_o, 32'h0);
        check("reset dmem_addr", dmem_addr_o, 32'h0);
        check("reset dmem_wdata", dmem_wdata_o, 32'h0);
        check("reset dmem_we", 32'(dmem_we_o), 32'd0);
        rstn_i = 1'b1;

        for (int i = 0; i < 19; i++) begin
            do_op(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, lat, err, we);
            $display("vec %0d: st=%0d f3=%03b addr=0x%08h wd=0x%08h -> lat=%0d err=%0d we=%0d rdata=0x%08h mem[%0d]=0x%08h",
                     i, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, lat, err, we, rdata_o,
                     vecs[i].midx, mem[vecs[i].midx]);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].err));
            check($sformatf("vec%0d we_cycles", i), 32'(we), 32'(vecs[i].we));
            check($sformatf("vec%0d rdata", i), rdata_o, vecs[i].rdata);
            check($sformatf("vec%0d mem", i), mem[vecs[i].midx], vecs[i].mval);
        end

        // Busy handling: req_i held high across two SWs.
        @(negedge clk_i);
        guard = 0;
        while (!ready_o && guard < 20) begin @(negedge clk_i); guard++; end
        is_store_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h24; wdata_i = 32'hA5A5A5A5;
        req_i = 1'b1;
        we_cnt = 0; done_cnt = 0; we_first = -1; we_second = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_i);
            if (dmem_we_o) begin
                we_cnt++;
                if (we_first < 0) we_first = c; else if (we_second < 0) we_second = c;
                addr_i = 32'h28; wdata_i = 32'h5A5A5A5A;
            end
            if (done_o) done_cnt++;
            if (done_cnt == 2) begin
                req_i = 1'b0;
                break;
            end
        end
        req_i = 1'b0;
        @(negedge clk_i);
        $display("busy: we_cnt=%0d done_cnt=%0d we@%0d,%0d mem[9]=0x%08h mem[10]=0x%08h",
                 we_cnt, done_cnt, we_first, we_second, mem[9], mem[10]);
        check("busy we count", 32'(we_cnt), 32'd2);
        check("busy done count", 32'(done_cnt), 32'd2);
        check("busy first write cycle", 32'(we_first), 32'd1);
        check("busy second write cycle", 32'(we_second), 32'd4);
        check("busy mem9", mem[9], 32'hA5A5A5A5);
        check("busy mem10", mem[10], 32'h5A5A5A5A);

        // Reset while in WR of SB 0x11.
        @(negedge clk_i);
        guard = 0;
        while (!ready_o && guard < 20) begin @(negedge clk_i); guard++; end
        is_store_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h11; wdata_i = 32'h000000EE;
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        check("rst pre we", 32'(dmem_we_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        check("rst we drops", 32'(dmem_we_o), 32'd0);
        check("rst done low", 32'(done_o), 32'd0);
        check("rst rdata", rdata_o, 32'h0);
        check("rst dmem_addr", dmem_addr_o, 32'h0);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (done_o) done_seen++;
        end
        $display("reset-in-WR: ready=%0d done_seen=%0d mem[4]=0x%08h", ready_o, done_seen, mem[4]);
        check("rst ready after", 32'(ready_o), 32'd1);
        check("rst no done", 32'(done_seen), 32'd0);
        check("rst mem4 unchanged", mem[4], 32'hBEEFCCBB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
